lsu_bus_bridge: RTL and testbench
=================================

Name: lsu_bus_bridge

Overview:
- Load/store unit between the EXE/MEM pipeline registers and an external data-memory bus with a req/gnt/rvalid handshake. Replaces the single-cycle dataMem path once data memory moves off-core.
- Byte-lane alignment, load sign/zero extension, misalignment and illegal-width detection, and a bus timeout.
- Drives stall back to the pipeline while a bus transaction is outstanding.

Parameters:
TIMEOUT_CYCLES, 255, cycles spent in REQ+WAIT before the transaction is abandoned with bus_err (must be >=2, max 65535)

Ports:
Clock  in  1  rising-edge clock
nReset  in  1  asynchronous active-low reset
Rmem  in  1  load request from EXE stage register
Wmem  in  1  store request from EXE stage register
func3  in  3  RV32I width/sign code of the access
addr  in  32  byte address (ALU result)
wdata  in  32  store data (rs2), low-justified
memOut  out  32  load result, aligned and extended, registered
stall  out  1  pipeline hold; 1 while an accepted access is not complete
access_err  out  1  one-cycle pulse: misaligned, illegal func3, or Rmem&Wmem
bus_err  out  1  one-cycle pulse: transaction timed out
bus_req  out  1  bus request, registered
bus_we  out  1  1 = write
bus_be  out  4  byte enables
bus_addr  out  32  word address, bits[1:0] always 0
bus_wdata  out  32  lane-shifted store data
bus_gnt  in  1  request accepted by slave
bus_rvalid  in  1  read data valid
bus_rdata  in  32  read data word

Behaviour:
- Reset (async, nReset=0): state IDLE; memOut, bus_be, bus_addr, bus_wdata = 0; bus_req, bus_we, access_err, bus_err, timeout counter = 0. bus_req drops immediately even mid-transaction; any in-flight beat is abandoned.
- Access present = Rmem|Wmem.
- Error detection (combinational, IDLE only). Error if any of:
  - Rmem&Wmem
  - func3 in {011,110,111}
  - store func3 in {100,101}
  - halfword with addr[0]=1
  - word with addr[1:0]!=0
- On error: no bus activity, access_err=1 for the cycle, stall=0, memOut unchanged.
- stall = (IDLE & access & !error) | REQ | WAIT. stall=0 in DONE, so the pipeline advances at the end of the DONE cycle.
- IDLE -> REQ on a valid access. Registers at that edge:
  - bus_addr = {addr[31:2],2'b00}
  - bus_we = Wmem
  - bus_be: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111
  - bus_wdata: store data replicated across lanes (byte x4, half x2)
- REQ: bus_req=1; addr/we/be/wdata held stable until bus_gnt.
  - gnt&we -> DONE (store complete on grant).
  - gnt&!we -> WAIT.
  - bus_req drops on the edge where gnt is sampled.
- WAIT: bus_req=0. On bus_rvalid, memOut <= extract(bus_rdata, addr[1:0], func3) -> DONE.
  - LB/LH: sign-extend. LBU/LHU: zero-extend. LW: passthrough.
  - Lane select uses the addr[1:0] captured at acceptance.
- DONE: one cycle; inputs ignored (still the same stalled instruction); -> IDLE.
- Timeout counter:
  - Cleared on entering REQ; increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES-1 without completion: -> DONE, bus_req=0, bus_err pulse; memOut <= 0 for loads.
- Ignored events: bus_rvalid outside WAIT; bus_gnt outside REQ.
- Simultaneous gnt and rvalid in REQ: gnt taken; rvalid ignored (the slave must return data at least one cycle after grant).
- memOut holds its value between loads; stores never modify it.
- Latency: store = 1 (accept) + grant wait + 1 (DONE); load additionally waits for rvalid. Minimum 3 stalled cycles excluding DONE for a zero-wait load.

Decomposition:
- Shared package core_types_pkg gets:
  - lsu_state_t enum {IDLE, REQ, WAIT, DONE}
  - func3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101
  - packed struct lsu_bus_req_t {req, we, be, addr, wdata}
- One combinational sub-module, lsu_align, contains:
  - error check
  - store lane shift / byte-enable generation
  - load extract/extend

Test Plan:
- SW addr=0x100 wdata=0xDEADBEEF, gnt after 2 cycles -> bus_addr=0x100, be=1111, wdata=0xDEADBEEF; stall high 3 cycles then low in DONE.
- LB addr=0x203, rdata=0x80_00_00_00 one cycle after gnt -> memOut=0xFFFFFF80; LBU same -> 0x00000080.
- SH addr=0x42 wdata=0x0000ABCD -> be=1100, bus_wdata=0xABCDABCD, bus_addr=0x40.
- LW addr=0x101 -> access_err pulse, bus_req never asserts, stall=0, memOut unchanged; Rmem&Wmem together -> same.
- LH with gnt but no rvalid, TIMEOUT_CYCLES=8 -> bus_err pulse after 8 cycles in REQ+WAIT, memOut=0, stall released.
- nReset low while in WAIT -> bus_req/stall/outputs 0 immediately; late rvalid after reset release ignored, memOut stays 0.

Source files
------------

// File: rtl/core_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_types_pkg
//  Description : Shared types for the load/store unit: FSM state encoding,
//                RV32I load/store width codes and the registered bus request.
//  Revision    : 1.0 - initial release
// ============================================================================
package core_types_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    // func3 width/sign codes; bit 2 set means zero-extending load
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsu_bus_req_t;

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_align
//  Description : Combinational byte-lane logic for the LSU: access legality
//                check, store byte enables / lane replication, and load lane
//                extraction with sign or zero extension.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import core_types_pkg::*;
(
    input  logic        rmem,
    input  logic        wmem,
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [2:0]  ld_func3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic        error,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Legality: conflicting request, unknown width, unsigned store, misalignment
    always_comb begin
        error = 1'b0;
        if (rmem && wmem) error = 1'b1;
        case (func3)
            F3_B, F3_BU: ;
            F3_H, F3_HU: if (addr_lo[0]) error = 1'b1;
            F3_W:        if (addr_lo != 2'b00) error = 1'b1;
            default:     error = 1'b1;
        endcase
        if (wmem && func3[2]) error = 1'b1;
    end

    // Store side: byte enables follow the offset, data is replicated on every lane
    always_comb begin
        case (func3[1:0])
            2'b00: begin
                be         = 4'b0001 << addr_lo;
                lane_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                be         = 4'b0011 << addr_lo;
                lane_wdata = {2{wdata[15:0]}};
            end
            default: begin
                be         = 4'b1111;
                lane_wdata = wdata;
            end
        endcase
    end

    // Load side: pick the addressed lane using the offset captured at acceptance
    always_comb begin
        case (ld_off)
            2'd0:    rd_byte = rdata[7:0];
            2'd1:    rd_byte = rdata[15:8];
            2'd2:    rd_byte = rdata[23:16];
            default: rd_byte = rdata[31:24];
        endcase
        rd_half = ld_off[1] ? rdata[31:16] : rdata[15:0];
        case (ld_func3)
            F3_B:    load_data = {{24{rd_byte[7]}}, rd_byte};
            F3_BU:   load_data = {24'd0, rd_byte};
            F3_H:    load_data = {{16{rd_half[15]}}, rd_half};
            F3_HU:   load_data = {16'd0, rd_half};
            default: load_data = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_bus_bridge
//  Description : Load/store unit bridging the EXE/MEM stage to a req/gnt/
//                rvalid data-memory bus. Stalls the pipeline while a bus
//                transaction is outstanding and abandons it after a timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_bus_bridge
    import core_types_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        Clock,
    input  logic        nReset,
    input  logic        Rmem,
    input  logic        Wmem,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] memOut,
    output logic        stall,
    output logic        access_err,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam logic [15:0] TLIM = 16'(TIMEOUT_CYCLES - 1);

    lsu_state_t   state;
    lsu_bus_req_t bus_q;
    logic [15:0]  tcnt;
    logic [1:0]   ld_off;
    logic [2:0]   ld_func3;

    logic         access;
    logic         error;
    logic         timed_out;
    logic [3:0]   be_sel;
    logic [31:0]  lane_wdata;
    logic [31:0]  load_data;

    lsu_align u_align (
        .rmem       (Rmem),
        .wmem       (Wmem),
        .func3      (func3),
        .addr_lo    (addr[1:0]),
        .wdata      (wdata),
        .ld_func3   (ld_func3),
        .ld_off     (ld_off),
        .rdata      (bus_rdata),
        .error      (error),
        .be         (be_sel),
        .lane_wdata (lane_wdata),
        .load_data  (load_data)
    );

    assign access    = Rmem | Wmem;
    assign timed_out = (tcnt == TLIM);

    // Hold the pipeline from the accepting cycle until DONE; released while in reset
    assign stall = nReset & (((state == IDLE) & access & ~error)
                             | (state == REQ) | (state == WAIT));

    assign bus_req   = bus_q.req;
    assign bus_we    = bus_q.we;
    assign bus_be    = bus_q.be;
    assign bus_addr  = bus_q.addr;
    assign bus_wdata = bus_q.wdata;

    // Transaction FSM with registered bus request, load result and error pulses
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state      <= IDLE;
            bus_q      <= '0;
            memOut     <= '0;
            access_err <= 1'b0;
            bus_err    <= 1'b0;
            tcnt       <= '0;
            ld_off     <= '0;
            ld_func3   <= '0;
        end else begin
            access_err <= 1'b0;
            bus_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (access) begin
                        if (error) begin
                            access_err <= 1'b1;
                        end else begin
                            bus_q.req   <= 1'b1;
                            bus_q.we    <= Wmem;
                            bus_q.be    <= be_sel;
                            bus_q.addr  <= {addr[31:2], 2'b00};
                            bus_q.wdata <= lane_wdata;
                            ld_off      <= addr[1:0];
                            ld_func3    <= func3;
                            tcnt        <= '0;
                            state       <= REQ;
                        end
                    end
                end
                REQ: begin
                    tcnt <= tcnt + 16'd1;
                    if (bus_gnt) begin
                        // a store completes on grant; a load waits for its data beat
                        bus_q.req <= 1'b0;
                        state     <= bus_q.we ? DONE : WAIT;
                    end else if (timed_out) begin
                        bus_q.req <= 1'b0;
                        bus_err   <= 1'b1;
                        if (!bus_q.we) memOut <= '0;
                        state     <= DONE;
                    end
                end
                WAIT: begin
                    tcnt <= tcnt + 16'd1;
                    if (bus_rvalid) begin
                        memOut <= load_data;
                        state  <= DONE;
                    end else if (timed_out) begin
                        memOut  <= '0;
                        bus_err <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_bus_bridge
//  Description : Directed bench for lsu_bus_bridge. Stimulus pushes expected
//                events into a queue; a monitor pops and compares on each bus
//                grant, access error, bus error and completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_bus_bridge;
    import core_types_pkg::*;

    localparam int TO     = 8;
    localparam int K_BEAT = 0;
    localparam int K_DONE = 1;
    localparam int K_AERR = 2;
    localparam int K_BERR = 3;

    logic        Clock  = 1'b0;
    logic        nReset = 1'b0;
    logic        Rmem   = 1'b0;
    logic        Wmem   = 1'b0;
    logic [2:0]  func3  = 3'd0;
    logic [31:0] addr   = 32'd0;
    logic [31:0] wdata  = 32'd0;
    logic [31:0] memOut;
    logic        stall;
    logic        access_err;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    // slave model (responder) and manual overrides
    bit          resp_on  = 1'b1;
    int          gnt_wait = 0;
    int          rv_wait  = 0;
    bit          rv_en    = 1'b1;
    logic [31:0] rv_data  = 32'd0;
    logic        r_gnt = 1'b0, r_rvalid = 1'b0;
    logic [31:0] r_rdata = 32'd0;
    logic        m_gnt = 1'b0, m_rvalid = 1'b0;
    logic [31:0] m_rdata = 32'd0;

    assign bus_gnt    = resp_on ? r_gnt    : m_gnt;
    assign bus_rvalid = resp_on ? r_rvalid : m_rvalid;
    assign bus_rdata  = resp_on ? r_rdata  : m_rdata;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          kind;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mem;
        int          stalls;
    } exp_t;

    exp_t q[$];

    lsu_bus_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .Clock      (Clock),
        .nReset     (nReset),
        .Rmem       (Rmem),
        .Wmem       (Wmem),
        .func3      (func3),
        .addr       (addr),
        .wdata      (wdata),
        .memOut     (memOut),
        .stall      (stall),
        .access_err (access_err),
        .bus_err    (bus_err),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_be     (bus_be),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_beat(input logic we, input logic [3:0] be, input logic [31:0] a,
                            input logic [31:0] wd);
        exp_t e;
        e.kind = K_BEAT; e.we = we; e.be = be; e.addr = a; e.wdata = wd;
        e.mem = 32'd0; e.stalls = 0;
        q.push_back(e);
    endtask

    task automatic exp_end(input int kind, input logic [31:0] mem, input int stalls);
        exp_t e;
        e.kind = kind; e.we = 1'b0; e.be = 4'd0; e.addr = 32'd0; e.wdata = 32'd0;
        e.mem = mem; e.stalls = stalls;
        q.push_back(e);
    endtask

    task automatic pop(input int k, output exp_t e, output bit ok);
        e.kind = -1; e.we = 1'b0; e.be = 4'd0; e.addr = 32'd0; e.wdata = 32'd0;
        e.mem = 32'd0; e.stalls = 0;
        ok = 1'b0;
        if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got kind %0d expected none", k);
        end else begin
            e  = q.pop_front();
            ok = 1'b1;
            chk("event_kind", 32'(k), 32'(e.kind));
        end
    endtask

    // Present one access (called at posedge+1 in IDLE) and wait until it completes
    task automatic issue(input logic rm, input logic wm, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input bit is_err);
        int n;
        Rmem = rm; Wmem = wm; func3 = f3; addr = a; wdata = wd;
        @(negedge Clock);
        if (is_err) chk("err_no_stall", 32'(stall), 32'd0);
        n = 0;
        while (stall && n < 60) begin
            @(negedge Clock);
            n++;
        end
        if (n >= 60) begin
            total++;
            bad++;
            $display("FAIL completion_bound: got stall after %0d cycles expected release", n);
        end
        @(posedge Clock); #1;
        Rmem = 1'b0; Wmem = 1'b0; func3 = 3'd0; addr = 32'd0; wdata = 32'd0;
        repeat (2) begin @(posedge Clock); #1; end
    endtask

    // Slave: grant after gnt_wait request cycles, return data rv_wait cycles after grant
    initial begin
        bit rd_pending;
        int req_cnt;
        int rv_cnt;
        rd_pending = 1'b0; req_cnt = 0; rv_cnt = 0;
        forever begin
            @(posedge Clock); #1;
            r_gnt    = 1'b0;
            r_rvalid = 1'b0;
            if (!nReset || !resp_on) begin
                rd_pending = 1'b0;
                req_cnt    = 0;
            end else begin
                if (!stall) rd_pending = 1'b0;
                if (rd_pending && rv_en) begin
                    if (rv_cnt == rv_wait) begin
                        r_rvalid   = 1'b1;
                        r_rdata    = rv_data;
                        rd_pending = 1'b0;
                    end
                    rv_cnt++;
                end
                if (bus_req) begin
                    if (req_cnt == gnt_wait) begin
                        r_gnt   = 1'b1;
                        req_cnt = 0;
                        if (!bus_we) begin
                            rd_pending = 1'b1;
                            rv_cnt     = 0;
                        end
                    end else begin
                        req_cnt++;
                    end
                end else begin
                    req_cnt = 0;
                end
            end
        end
    end

    // Monitor: compare each observable DUT event against the next queued expectation
    initial begin
        bit   prev_stall;
        int   stall_run;
        exp_t e;
        bit   ok;
        prev_stall = 1'b0;
        stall_run  = 0;
        forever begin
            @(negedge Clock);
            if (!nReset) begin
                prev_stall = 1'b0;
                stall_run  = 0;
            end else begin
                if (stall) stall_run++;
                if (bus_req && bus_gnt) begin
                    pop(K_BEAT, e, ok);
                    if (ok) begin
                        chk("beat_we",    32'(bus_we), 32'(e.we));
                        chk("beat_be",    32'(bus_be), 32'(e.be));
                        chk("beat_addr",  bus_addr,    e.addr);
                        chk("beat_wdata", bus_wdata,   e.wdata);
                    end
                end
                if (access_err) begin
                    pop(K_AERR, e, ok);
                    if (ok) begin
                        chk("aerr_memOut",  memOut,       e.mem);
                        chk("aerr_bus_req", 32'(bus_req), 32'd0);
                    end
                end
                if (bus_err) begin
                    pop(K_BERR, e, ok);
                    if (ok) begin
                        chk("berr_memOut", memOut,         e.mem);
                        chk("berr_stalls", 32'(stall_run), 32'(e.stalls));
                    end
                    stall_run = 0;
                end else if (prev_stall && !stall) begin
                    pop(K_DONE, e, ok);
                    if (ok) begin
                        chk("done_memOut", memOut,         e.mem);
                        chk("done_stalls", 32'(stall_run), 32'(e.stalls));
                    end
                    stall_run = 0;
                end
                prev_stall = stall;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        #12;
        chk("rst_memOut",     memOut,          32'd0);
        chk("rst_bus_req",    32'(bus_req),    32'd0);
        chk("rst_stall",      32'(stall),      32'd0);
        chk("rst_bus_be",     32'(bus_be),     32'd0);
        chk("rst_bus_addr",   bus_addr,        32'd0);
        chk("rst_bus_wdata",  bus_wdata,       32'd0);
        chk("rst_access_err", 32'(access_err), 32'd0);
        chk("rst_bus_err",    32'(bus_err),    32'd0);
        @(negedge Clock); nReset = 1'b1;
        @(posedge Clock); #1;

        // SW 0x100, grant on the second request cycle
        gnt_wait = 1;
        exp_beat(1'b1, 4'b1111, 32'h100, 32'hDEADBEEF);
        exp_end(K_DONE, 32'd0, 3);
        issue(1'b0, 1'b1, F3_W, 32'h100, 32'hDEADBEEF, 1'b0);

        // LW 0x200, zero-wait
        gnt_wait = 0; rv_wait = 0; rv_data = 32'h12345678;
        exp_beat(1'b0, 4'b1111, 32'h200, 32'd0);
        exp_end(K_DONE, 32'h12345678, 3);
        issue(1'b1, 1'b0, F3_W, 32'h200, 32'd0, 1'b0);

        // LB / LBU 0x203, data one cycle after grant
        rv_data = 32'h80000000;
        exp_beat(1'b0, 4'b1000, 32'h200, 32'd0);
        exp_end(K_DONE, 32'hFFFFFF80, 3);
        issue(1'b1, 1'b0, F3_B, 32'h203, 32'd0, 1'b0);
        exp_beat(1'b0, 4'b1000, 32'h200, 32'd0);
        exp_end(K_DONE, 32'h00000080, 3);
        issue(1'b1, 1'b0, F3_BU, 32'h203, 32'd0, 1'b0);

        // SH 0x42 and SB 0x31: stores leave memOut alone
        exp_beat(1'b1, 4'b1100, 32'h40, 32'hABCDABCD);
        exp_end(K_DONE, 32'h00000080, 2);
        issue(1'b0, 1'b1, F3_H, 32'h42, 32'h0000ABCD, 1'b0);
        gnt_wait = 2;
        exp_beat(1'b1, 4'b0010, 32'h30, 32'hA5A5A5A5);
        exp_end(K_DONE, 32'h00000080, 4);
        issue(1'b0, 1'b1, F3_B, 32'h31, 32'h000000A5, 1'b0);

        // LH upper half with grant and data waits; LHU lower half
        gnt_wait = 1; rv_wait = 1; rv_data = 32'h80017FFF;
        exp_beat(1'b0, 4'b1100, 32'h10, 32'd0);
        exp_end(K_DONE, 32'hFFFF8001, 5);
        issue(1'b1, 1'b0, F3_H, 32'h12, 32'd0, 1'b0);
        gnt_wait = 0; rv_wait = 0; rv_data = 32'h8001F00D;
        exp_beat(1'b0, 4'b0011, 32'h10, 32'd0);
        exp_end(K_DONE, 32'h0000F00D, 3);
        issue(1'b1, 1'b0, F3_HU, 32'h10, 32'd0, 1'b0);

        // illegal accesses: no bus activity, memOut unchanged
        exp_end(K_AERR, 32'h0000F00D, 0);
        issue(1'b1, 1'b0, F3_W, 32'h101, 32'd0, 1'b1);
        exp_end(K_AERR, 32'h0000F00D, 0);
        issue(1'b1, 1'b1, F3_W, 32'h100, 32'd0, 1'b1);
        exp_end(K_AERR, 32'h0000F00D, 0);
        issue(1'b1, 1'b0, F3_H, 32'h13, 32'd0, 1'b1);
        exp_end(K_AERR, 32'h0000F00D, 0);
        issue(1'b0, 1'b1, F3_BU, 32'h0, 32'h11, 1'b1);
        exp_end(K_AERR, 32'h0000F00D, 0);
        issue(1'b1, 1'b0, 3'b011, 32'h0, 32'd0, 1'b1);

        // LH granted but never answered: timeout after TO cycles in REQ+WAIT
        rv_en = 1'b0;
        exp_beat(1'b0, 4'b0011, 32'h20, 32'd0);
        exp_end(K_BERR, 32'd0, 1 + TO);
        issue(1'b1, 1'b0, F3_H, 32'h20, 32'd0, 1'b0);
        rv_en = 1'b1;

        // LW 0x0 to leave a nonzero memOut before the reset test
        rv_data = 32'hCAFEF00D;
        exp_beat(1'b0, 4'b1111, 32'h0, 32'd0);
        exp_end(K_DONE, 32'hCAFEF00D, 3);
        issue(1'b1, 1'b0, F3_W, 32'h0, 32'd0, 1'b0);

        // reset while waiting for read data, then a stray rvalid
        resp_on = 1'b0;
        exp_beat(1'b0, 4'b1111, 32'h300, 32'd0);
        Rmem = 1'b1; func3 = F3_W; addr = 32'h300;
        @(posedge Clock); #1;
        m_gnt = 1'b1;
        @(posedge Clock); #1;
        m_gnt = 1'b0;
        @(posedge Clock); #3;
        nReset = 1'b0;
        #1;
        chk("mid_rst_bus_req",  32'(bus_req), 32'd0);
        chk("mid_rst_stall",    32'(stall),   32'd0);
        chk("mid_rst_memOut",   memOut,       32'd0);
        chk("mid_rst_bus_be",   32'(bus_be),  32'd0);
        chk("mid_rst_bus_addr", bus_addr,     32'd0);
        Rmem = 1'b0; func3 = 3'd0; addr = 32'd0;
        @(negedge Clock); #1;
        nReset = 1'b1;
        @(posedge Clock); #1;
        m_rvalid = 1'b1; m_rdata = 32'hFFFFFFFF;
        @(posedge Clock); #1;
        m_rvalid = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        chk("late_rv_memOut",  memOut,       32'd0);
        chk("late_rv_stall",   32'(stall),   32'd0);
        chk("late_rv_bus_req", 32'(bus_req), 32'd0);

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
